// File: rtl/serial_alu.sv
// Bit-serial ALU: consumes LSB-first operand streams from the GPR file, emits one
// result bit per cycle, drives GPR shift/write for WIDTH cycles and holds carry/zero flags.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | waiting for i_start; op, carry seed and zero accumulator load
// S_RUN  | WIDTH cycles, one operand/result bit per cycle
// S_DONE | one-cycle completion pulse, flags already valid

module serial_alu #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic             i_a_bit,
    input  logic             i_b_bit,
    output logic             o_shift,
    output logic             o_write,
    output logic             o_res_bit,
    output logic [CNT_W-1:0] o_bit_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_carry,
    output logic             o_zero
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       op_q;
    logic             carry_q;
    logic             zacc_q;
    logic             carry_flag_q;
    logic             zero_flag_q;

    logic             run;
    logic             last_bit;
    logic             is_arith;
    logic             b_eff;
    logic             sum_bit;
    logic             carry_nxt;
    logic             res_raw;
    logic             res_bit;
    logic             shift_en;
    logic             busy;
    logic             done;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                shift_en = 1'b1;
                busy     = 1'b1;
                if (last_bit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign run      = (state_q == S_RUN);
    assign last_bit = (cnt_q == LAST_IDX);

    // SUB is a + ~b + 1: invert b and seed the carry with 1 at start.
    assign is_arith  = ~op_q[1];
    assign b_eff     = i_b_bit ^ (op_q == OP_SUB);
    assign sum_bit   = i_a_bit ^ b_eff ^ carry_q;
    assign carry_nxt = (i_a_bit & b_eff) | (i_a_bit & carry_q) | (b_eff & carry_q);

    always_comb begin
        res_raw = 1'b0;
        case (op_q)
            OP_ADD:  res_raw = sum_bit;
            OP_SUB:  res_raw = sum_bit;
            OP_AND:  res_raw = i_a_bit & i_b_bit;
            OP_XOR:  res_raw = i_a_bit ^ i_b_bit;
            default: res_raw = 1'b0;
        endcase
    end

    assign res_bit = run ? res_raw : 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_q        <= '0;
            op_q         <= OP_ADD;
            carry_q      <= 1'b0;
            zacc_q       <= 1'b0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        op_q    <= i_op;
                        cnt_q   <= '0;
                        carry_q <= (i_op == OP_SUB);
                        zacc_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    carry_q <= is_arith ? carry_nxt : 1'b0;
                    zacc_q  <= zacc_q & ~res_bit;
                    if (last_bit) begin
                        // Wrap explicitly so non-power-of-two widths restart cleanly.
                        cnt_q        <= '0;
                        carry_flag_q <= is_arith ? carry_nxt : 1'b0;
                        zero_flag_q  <= zacc_q & ~res_bit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_shift   = shift_en;
    assign o_write   = shift_en;
    assign o_busy    = busy;
    assign o_done    = done;
    assign o_res_bit = res_bit;
    assign o_bit_idx = run ? cnt_q : '0;
    assign o_carry   = carry_flag_q;
    assign o_zero    = zero_flag_q;

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: directed cases plus random ops against an
// arithmetic reference model; a GPR shift-register model feeds the operand bits.

module tb_serial_alu;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [1:0]   i_op;
    logic         i_a_bit;
    logic         i_b_bit;
    logic         o_shift;
    logic         o_write;
    logic         o_res_bit;
    logic [2:0]   o_bit_idx;
    logic         o_busy;
    logic         o_done;
    logic         o_carry;
    logic         o_zero;

    serial_alu #(.WIDTH(W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_op      (i_op),
        .i_a_bit   (i_a_bit),
        .i_b_bit   (i_b_bit),
        .o_shift   (o_shift),
        .o_write   (o_write),
        .o_res_bit (o_res_bit),
        .o_bit_idx (o_bit_idx),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_carry   (o_carry),
        .o_zero    (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        int           start;
    } exp_t;

    exp_t   exp_q[$];
    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;

    logic [W-1:0] ld_a = '0;
    logic [W-1:0] ld_b = '0;
    logic [W-1:0] a_sr = '0;
    logic [W-1:0] b_sr = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // GPR model: loads when the sequencer's start is accepted, shifts on o_shift.
    always @(posedge i_clk) begin
        if (i_start && !o_busy && !o_done) begin
            a_sr <= ld_a;
            b_sr <= ld_b;
        end else if (o_shift) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
        end
    end
    assign i_a_bit = a_sr[0];
    assign i_b_bit = b_sr[0];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input int start);
        exp_t e;
        logic [W:0] s;
        e.start = start;
        e.c     = 1'b0;
        case (op)
            2'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                e.res = s[W-1:0];
                e.c   = s[W];
            end
            2'd1: begin
                e.res = a - b;
                e.c   = (a >= b);
            end
            2'd2:    e.res = a & b;
            default: e.res = a ^ b;
        endcase
        e.z = (e.res == '0);
        return e;
    endfunction

    // Monitor: assembles the result stream and checks it whenever o_done appears.
    int           mcnt   = 0;
    logic [W-1:0] racc   = '0;
    logic         last_c = 1'b0;
    logic         last_z = 1'b0;

    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst) begin
            mcnt   = 0;
            racc   = '0;
            last_c = 1'b0;
            last_z = 1'b0;
        end else begin
            if (o_shift) begin
                if (mcnt == 0) begin
                    chk("carry_held", o_carry, last_c);
                    chk("zero_held", o_zero, last_z);
                end
                chk("bit_idx", o_bit_idx, mcnt);
                chk("run_ctl", {o_write, o_busy, o_done}, 3'b110);
                if (mcnt < W) racc[mcnt] = o_res_bit;
                mcnt++;
            end else begin
                chk("idle_ctl", {o_write, o_busy, o_res_bit, o_bit_idx}, '0);
            end
            if (o_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", racc, e.res);
                    chk("shift_cycles", mcnt, W);
                    chk("carry", o_carry, e.c);
                    chk("zero", o_zero, e.z);
                    chk("done_time", cyc, e.start + W);
                    last_c = e.c;
                    last_z = e.z;
                end
                mcnt = 0;
                racc = '0;
            end
        end
    end

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (o_done) seen = 1;
            else @(negedge i_clk);
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        i_op    = op;
        ld_a    = a;
        ld_b    = b;
        i_start = 1'b1;
        exp_q.push_back(model(op, a, b, cyc + 1));
        @(negedge i_clk);
        i_start = 1'b0;
        i_op    = 2'($urandom);
        wait_done();
        @(negedge i_clk);
    endtask

    initial begin
        int e0;
        bit hit;
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_op    = 2'd0;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", {o_shift, o_write, o_busy, o_done, o_carry, o_zero, o_res_bit, o_bit_idx}, '0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("post_reset_idle", {o_shift, o_busy, o_done, o_carry, o_zero}, '0);

        do_op(2'd0, 8'h35, 8'h4A);
        do_op(2'd0, 8'hFF, 8'h01);
        do_op(2'd0, 8'h01, 8'h01);
        do_op(2'd1, 8'h10, 8'h01);
        do_op(2'd1, 8'h00, 8'h01);
        do_op(2'd1, 8'h5A, 8'h5A);
        do_op(2'd2, 8'hF0, 8'h3C);
        do_op(2'd3, 8'hAA, 8'hAA);
        do_op(2'd3, 8'hAA, 8'h55);

        // Start pulsed mid-RUN with a different op must be ignored.
        i_op    = 2'd0;
        ld_a    = 8'h35;
        ld_b    = 8'h4A;
        i_start = 1'b1;
        exp_q.push_back(model(2'd0, 8'h35, 8'h4A, cyc + 1));
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (2) @(negedge i_clk);
        i_start = 1'b1;
        i_op    = 2'd1;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_done();
        repeat (4) @(negedge i_clk);

        // Start held high: back-to-back ops every W+2 edges.
        i_op    = 2'd0;
        ld_a    = 8'h81;
        ld_b    = 8'h90;
        e0      = cyc + 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(model(2'd0, 8'h81, 8'h90, e0 + k * (W + 2)));
        i_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            wait_done();
        end
        i_start = 1'b0;
        @(negedge i_clk);

        // Abort mid-RUN with reset after leaving both flags set.
        do_op(2'd0, 8'hFF, 8'h01);
        i_op    = 2'd1;
        ld_a    = 8'h77;
        ld_b    = 8'h12;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (o_busy && o_bit_idx == 3'd4) hit = 1;
            else @(negedge i_clk);
        end
        chk("reach_idx4", hit, 1);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("abort_ctl", {o_busy, o_shift, o_write, o_done}, 4'b0000);
        chk("abort_flags", {o_carry, o_zero}, 2'b00);
        i_rst = 1'b1;
        repeat (15) @(negedge i_clk);

        for (int n = 0; n < 40; n++) begin
            do_op(2'($urandom), W'($urandom), W'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge i_clk);
        end

        repeat (3) @(negedge i_clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
